serial_tc_decoder: RTL and testbench
====================================

Name: serial_tc_decoder

Overview:
- Receive end of the bit-serial two's-complement link.
- Takes the LSB-first serial stream produced by the serial negator and re-applies the serial two's-complement rule: pass bits up to and including the first 1, then invert the rest. This recovers the original word.
- Deserializes the word and presents it on a one-entry valid/ready parallel output, with sticky error flags.

Parameters:
- WIDTH, 8, frame length in bits (WIDTH >= 2).
- DECODE, 1, 1 = apply the serial two's-complement transform; 0 = raw deserialization (bypass).

Ports:
- t_clk  in  1  clock; all state updates on the rising edge.
- r  in  1  reset, asynchronous, active-low.
- i_bit  in  1  serial data bit, LSB first.
- i_en  in  1  i_bit is valid this cycle.
- i_start  in  1  qualified by i_en; marks bit 0 (LSB) of a frame.
- o_data  out  WIDTH  decoded word.
- o_valid  out  1  o_data holds an unconsumed word.
- o_ready  in  1  downstream accepts o_data when o_valid=1.
- o_busy  out  1  a frame is in progress (state SHIFT).
- o_ovr  out  1  sticky: a completed frame was dropped because the buffer was full.
- o_frm_err  out  1  sticky: i_start arrived mid-frame.

Behaviour:
- Reset (r=0, async): state IDLE, cnt=0, seen_one=0, shift register=0, o_data=0, o_valid=0, o_busy=0, o_ovr=0, o_frm_err=0.
- Bit transform (DECODE=1): out_bit = seen_one ? ~i_bit : i_bit. seen_one is updated as seen_one | i_bit, and is cleared at bit 0 of each frame, so bit 0 always passes unchanged.
- Bit transform (DECODE=0): out_bit = i_bit.
- Shift: out_bit enters the MSB and the register shifts right, so after WIDTH bits bit 0 sits at the LSB.
- FSM IDLE:
  - i_en & i_start: take bit 0, cnt=1, go to SHIFT.
  - i_en & !i_start: ignore the bit; no flag.
- FSM SHIFT, on i_en:
  - Shift in the bit and increment cnt.
  - When the sampled bit is bit WIDTH-1: complete the frame and return to IDLE.
- i_en=0 holds all state; gaps between bits are unlimited.
- i_start during SHIFT: set o_frm_err, discard the partial frame, and treat this bit as bit 0 of a new frame (cnt=1, seen_one re-initialised, stay in SHIFT).
- Completion load: the word is registered into o_data and o_valid=1 at the same edge that samples the last bit. Latency: o_valid is visible the cycle after the final bit is presented.
- Output handshake:
  - Transfer occurs on an edge with o_valid & o_ready.
  - o_data is stable while o_valid & !o_ready.
  - o_valid falls after a transfer, unless a frame completes on the same edge; then o_data updates and o_valid stays 1 (no bubble, no loss).
- Overrun: frame completes while o_valid=1 and o_ready=0 → new word dropped, o_data unchanged, o_ovr=1.
- Sticky flags clear only on reset.
- o_busy = (state == SHIFT).
- Boundary cases:
  - All-zero frame decodes to 0.
  - Most-negative value (only the MSB set) decodes to itself, since it is self-inverse.
  - cnt saturates at WIDTH-1; no wrap inside a frame.
- Reset mid-frame: immediate return to the reset state; the partial word is lost with no flag.

Decomposition:
- Package serial_tc_pkg holds:
  - the default WIDTH constant;
  - the state enum (IDLE, SHIFT);
  - the counter width, $clog2(WIDTH).
- Sub-module tc_bit_stage: the seen_one flip-flop plus the conditional inverter, with a clear input driven at bit 0. It is reusable by the serial negator on the transmit side.

Test Plan (WIDTH=8, DECODE=1, o_ready=1 unless stated):
- Feed 1,1,0,1,1,1,1,1 (the encoding of −5, i.e. 0xFB) with i_start on the first bit → o_data=0x05, o_valid high for one cycle, the cycle after the last bit.
- Feed frame 0x00 and then 0x80 (the value as sent on the wire) → o_data=0x00, then o_data=0x80; o_ovr=0, o_frm_err=0.
- Hold o_ready=0 and send two frames → o_data keeps the first word and o_ovr=1. Then raise o_ready → one transfer, o_valid falls, o_ovr stays 1.
- Assert o_ready on exactly the edge a second frame completes → first word transferred, o_data updates to the second word, o_valid stays 1, o_ovr=0.
- Send i_start after 3 bits, then a full frame for 0xFF → o_frm_err=1, output equals the decode of the new frame only (0x01).
- Insert random i_en gaps within a frame, then assert r=0 mid-frame → gaps give the same result as the gapless case; reset immediately zeroes all outputs and the next frame decodes correctly.
- Repeat the first scenario with DECODE=0 → o_data=0xFB.

Source files
------------

// File: rtl/serial_tc_pkg.sv
// Shared definitions for the bit-serial two's-complement link.
//   WIDTH_DEF : default frame length in bits
//   state_e   : frame receive state (IDLE, SHIFT)
//   CNT_W_DEF : bit-counter width for the default frame length
package serial_tc_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/tc_bit_stage.sv
// Serial two's-complement bit stage: passes bits up to and including the
// first 1 of a frame, inverts every bit after it. Shared with the transmit
// side negator.
//   clk, rst_n : clock, async active-low reset
//   en         : advance the stage with i_bit this cycle
//   clr        : i_bit is bit 0 of a frame (forget previous ones)
//   i_bit      : incoming serial bit
//   out_bit_c  : transformed bit (combinational)
module tc_bit_stage #(
  parameter bit DECODE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic i_bit,
  output logic out_bit_c
);

  logic seen_one_q;
  logic seen_one_d;
  logic seen_eff_c;

  // Bit 0 must see a cleared history so it always passes unchanged.
  always_comb begin
    seen_eff_c = clr ? 1'b0 : seen_one_q;
    out_bit_c  = (DECODE && seen_eff_c) ? ~i_bit : i_bit;
    seen_one_d = en ? (seen_eff_c | i_bit) : seen_one_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

endmodule

// File: rtl/serial_tc_decoder.sv
// Receive end of the bit-serial two's-complement link. Re-applies the serial
// two's-complement rule to an LSB-first frame, deserializes it and presents
// the word on a one-entry valid/ready output with sticky error flags.
//   t_clk, r   : clock, async active-low reset
//   i_bit      : serial data bit, LSB first
//   i_en       : i_bit valid this cycle
//   i_start    : with i_en, marks bit 0 of a frame
//   o_data     : decoded word
//   o_valid    : o_data holds an unconsumed word
//   o_ready    : downstream accepts o_data
//   o_busy     : frame in progress
//   o_ovr      : sticky, completed frame dropped on a full buffer
//   o_frm_err  : sticky, i_start arrived mid-frame
module serial_tc_decoder
  import serial_tc_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter bit          DECODE = 1'b1
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             i_bit,
  input  logic             i_en,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_busy,
  output logic             o_ovr,
  output logic             o_frm_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-2:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;
  logic               frm_err_q, frm_err_d;

  logic               stage_en_c;
  logic               out_bit_c;
  logic [WIDTH-1:0]   word_c;
  logic               complete_c;

  // History only advances on bits that belong to a frame.
  assign stage_en_c = i_en & (i_start | (state_q == SHIFT));

  tc_bit_stage #(
    .DECODE (DECODE)
  ) u_bit_stage (
    .clk       (t_clk),
    .rst_n     (r),
    .en        (stage_en_c),
    .clr       (i_start),
    .i_bit     (i_bit),
    .out_bit_c (out_bit_c)
  );

  // New bit enters at the MSB; the full word is only meaningful on the last bit.
  assign word_c = {out_bit_c, sr_q};

  // Next-state, frame assembly and output handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    frm_err_d  = frm_err_q;
    complete_c = 1'b0;

    if (valid_q && o_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (i_en && i_start) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(1);
          sr_d    = word_c[WIDTH-1:1];
        end
      end
      SHIFT: begin
        if (i_en) begin
          sr_d = word_c[WIDTH-1:1];
          if (i_start) begin
            // Restart: the partial frame is abandoned, this bit is bit 0.
            frm_err_d = 1'b1;
            cnt_d     = CNT_W'(1);
          end else if (cnt_q == CNT_LAST) begin
            complete_c = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A completing frame may replace a word that transfers on the same edge.
    if (complete_c) begin
      if (!valid_q || o_ready) begin
        data_d  = word_c;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_ovr     = ovr_q;
  assign o_frm_err = frm_err_q;

endmodule

// File: tb/tb_serial_tc_decoder.sv
// Bench for serial_tc_decoder: a DECODE=1 and a DECODE=0 instance share one
// input stream; a frame-level model (bit queue, word = negation of the wire
// value) predicts all outputs every cycle.
module tb_serial_tc_decoder;

  localparam int unsigned W = 8;

  logic         t_clk = 1'b0;
  logic         r;
  logic         i_bit;
  logic         i_en;
  logic         i_start;
  logic         o_ready;

  logic [W-1:0] d1_data, d0_data;
  logic         d1_valid, d0_valid;
  logic         d1_busy, d0_busy;
  logic         d1_ovr, d0_ovr;
  logic         d1_err, d0_err;

  always #5 t_clk = ~t_clk;

  serial_tc_decoder #(.WIDTH(W), .DECODE(1'b1)) u_dec (
    .t_clk(t_clk), .r(r), .i_bit(i_bit), .i_en(i_en), .i_start(i_start),
    .o_data(d1_data), .o_valid(d1_valid), .o_ready(o_ready),
    .o_busy(d1_busy), .o_ovr(d1_ovr), .o_frm_err(d1_err)
  );

  serial_tc_decoder #(.WIDTH(W), .DECODE(1'b0)) u_raw (
    .t_clk(t_clk), .r(r), .i_bit(i_bit), .i_en(i_en), .i_start(i_start),
    .o_data(d0_data), .o_valid(d0_valid), .o_ready(o_ready),
    .o_busy(d0_busy), .o_ovr(d0_ovr), .o_frm_err(d0_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference model.
  logic [W-1:0] m_data, m_raw;
  logic         m_valid, m_busy, m_ovr, m_err;
  bit           q_bits[$];

  always @(posedge t_clk or negedge r) begin
    if (!r) begin
      m_data  = '0;
      m_raw   = '0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_ovr   = 1'b0;
      m_err   = 1'b0;
      q_bits.delete();
    end else begin
      logic done;
      logic xfer;
      logic [W-1:0] wire_w;
      done = 1'b0;
      xfer = m_valid & o_ready;
      if (i_en) begin
        if (i_start) begin
          if (m_busy) m_err = 1'b1;
          q_bits.delete();
          q_bits.push_back(i_bit);
          m_busy = 1'b1;
        end else if (m_busy) begin
          q_bits.push_back(i_bit);
          if (q_bits.size() == W) begin
            done   = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
      if (done) begin
        wire_w = '0;
        for (int i = 0; i < W; i++) wire_w[i] = q_bits[i];
        q_bits.delete();
        if (!m_valid || o_ready) begin
          m_raw   = wire_w;
          m_data  = W'(0) - wire_w;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge t_clk) begin
    chk("dec_data",  32'(d1_data),  32'(m_data));
    chk("dec_valid", 32'(d1_valid), 32'(m_valid));
    chk("dec_busy",  32'(d1_busy),  32'(m_busy));
    chk("dec_ovr",   32'(d1_ovr),   32'(m_ovr));
    chk("dec_err",   32'(d1_err),   32'(m_err));
    chk("raw_data",  32'(d0_data),  32'(m_raw));
    chk("raw_valid", 32'(d0_valid), 32'(m_valid));
    chk("raw_ovr",   32'(d0_ovr),   32'(m_ovr));
    chk("raw_err",   32'(d0_err),   32'(m_err));
  end

  task automatic drive(input logic b, input logic st);
    i_bit   = b;
    i_start = st;
    i_en    = 1'b1;
    @(posedge t_clk);
    #1;
    i_en    = 1'b0;
    i_start = 1'b0;
  endtask

  // Idle cycles with noise on the unqualified inputs.
  task automatic gap(input int n);
    repeat (n) begin
      i_bit   = 1'($urandom);
      i_start = 1'($urandom);
      @(posedge t_clk);
      #1;
    end
    i_start = 1'b0;
  endtask

  // rdy_mode: 0 leave o_ready, 1 raise it with the last bit, 2 randomize per bit.
  task automatic send_frame(input logic [W-1:0] w, input int gmax, input int rdy_mode);
    for (int i = 0; i < W; i++) begin
      if (gmax > 0) gap($urandom_range(0, gmax));
      if (rdy_mode == 2) o_ready = 1'($urandom);
      if (rdy_mode == 1 && i == W - 1) o_ready = 1'b1;
      drive(w[i], i == 0);
    end
  endtask

  initial begin
    logic [W-1:0] w;
    r = 1'b0; i_bit = 1'b0; i_en = 1'b0; i_start = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge t_clk);
    #1;
    chk("rst_data",  32'(d1_data),  32'h0);
    chk("rst_valid", 32'(d1_valid), 32'h0);
    chk("rst_busy",  32'(d1_busy),  32'h0);
    r = 1'b1;
    gap(2);

    // -5 on the wire decodes to 5; bypass keeps the wire value.
    send_frame(8'hFB, 0, 0);
    chk("s1_valid", 32'(d1_valid), 32'h1);
    chk("s1_data",  32'(d1_data),  32'h05);
    chk("s1_raw",   32'(d0_data),  32'hFB);
    @(posedge t_clk); #1;
    chk("s1_valid_drop", 32'(d1_valid), 32'h0);

    // Zero and most-negative values.
    send_frame(8'h00, 0, 0);
    chk("s2_zero", 32'(d1_data), 32'h00);
    send_frame(8'h80, 0, 0);
    chk("s2_minneg", 32'(d1_data), 32'h80);
    chk("s2_ovr", 32'(d1_ovr), 32'h0);
    chk("s2_err", 32'(d1_err), 32'h0);
    gap(2);

    // Ready rises on the edge the second frame completes: no bubble, no loss.
    o_ready = 1'b0;
    send_frame(8'h11, 0, 0);
    send_frame(8'hFB, 0, 1);
    chk("s4_valid", 32'(d1_valid), 32'h1);
    chk("s4_data",  32'(d1_data),  32'h05);
    chk("s4_ovr",   32'(d1_ovr),   32'h0);
    gap(2);

    // Overrun while stalled.
    o_ready = 1'b0;
    send_frame(8'h03, 1, 0);
    send_frame(8'h05, 1, 0);
    chk("s3_data", 32'(d1_data), 32'hFD);
    chk("s3_ovr",  32'(d1_ovr),  32'h1);
    o_ready = 1'b1;
    @(posedge t_clk); #1;
    chk("s3_drain", 32'(d1_valid), 32'h0);
    chk("s3_ovr_sticky", 32'(d1_ovr), 32'h1);

    // Start mid-frame.
    drive(1'b1, 1'b1); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
    send_frame(8'hFF, 0, 0);
    chk("s5_err",  32'(d1_err),  32'h1);
    chk("s5_data", 32'(d1_data), 32'h01);

    // Gapped frame, then reset mid-frame.
    send_frame(8'hFB, 3, 0);
    chk("s6_gap_data", 32'(d1_data), 32'h05);
    for (int i = 0; i < 4; i++) drive(1'($urandom), i == 0);
    #2 r = 1'b0;
    #1;
    chk("s6_rst_data",  32'(d1_data),  32'h0);
    chk("s6_rst_valid", 32'(d1_valid), 32'h0);
    chk("s6_rst_busy",  32'(d1_busy),  32'h0);
    chk("s6_rst_ovr",   32'(d1_ovr),   32'h0);
    chk("s6_rst_err",   32'(d1_err),   32'h0);
    @(posedge t_clk); #1;
    r = 1'b1;
    send_frame(8'hFB, 2, 0);
    chk("s6_after_rst", 32'(d1_data), 32'h05);

    // Random traffic: random words, gaps, back-pressure, stray and aborted frames.
    for (int f = 0; f < 40; f++) begin
      w = W'($urandom);
      if ($urandom_range(0, 4) == 0) drive(1'($urandom), 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        int n;
        n = $urandom_range(1, W - 2);
        for (int i = 0; i < n; i++) drive(1'($urandom), i == 0);
      end
      send_frame(w, 3, 2);
    end
    o_ready = 1'b1;
    gap(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
